// File: rtl/matrix_pkg.sv
// Shared constants, FSM encodings and width helpers for the matrix BRAM bank.
// Imported by bram_sdp and matrix_bram_bank.
package matrix_pkg;

  localparam int DATA_W    = 32;
  localparam int DEF_MAX_M = 16;
  localparam int DEF_MAX_K = 16;
  localparam int DEF_MAX_N = 16;

  localparam logic [1:0] ST_LOAD    = 2'd0;
  localparam logic [1:0] ST_KICK    = 2'd1;
  localparam logic [1:0] ST_COMPUTE = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  function automatic int addr_bits(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int dim_bits(input int max_dim);
    return $clog2(max_dim) + 1;
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// 32-bit simple dual-port RAM: one write port, one registered read port.
// Ports: clk, rst (read register only), we/waddr/wdata, re/raddr, rdata.
module bram_sdp
  import matrix_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents survive reset; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/matrix_bram_bank.sv
// Memory-side responder for the matmul engine: host loads A/B, engine
// reads A/B and writes C, then C is streamed back to the host row-major.
// Ports: load stream (ld_*), engine (eng_*, a_*, b_*, c_*), readback (rd_*).
module matrix_bram_bank
  import matrix_pkg::*;
#(
  parameter int MAX_M       = DEF_MAX_M,
  parameter int MAX_K       = DEF_MAX_K,
  parameter int MAX_N       = DEF_MAX_N,
  parameter int ADDR_A_BITS = addr_bits(MAX_M, MAX_K),
  parameter int ADDR_B_BITS = addr_bits(MAX_K, MAX_N),
  parameter int ADDR_C_BITS = addr_bits(MAX_M, MAX_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [dim_bits(MAX_M)-1:0] M_val,
  input  logic [dim_bits(MAX_N)-1:0] N_val,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic                   ld_sel,
  input  logic                   ld_last,
  input  logic [DATA_W-1:0]      ld_data,
  output logic                   ld_err,
  output logic                   eng_start,
  input  logic                   eng_done,
  input  logic [ADDR_A_BITS-1:0] a_addr,
  output logic [DATA_W-1:0]      a_rdata,
  input  logic [ADDR_B_BITS-1:0] b_addr,
  output logic [DATA_W-1:0]      b_rdata,
  input  logic                   c_we,
  input  logic [ADDR_C_BITS-1:0] c_addr,
  input  logic [DATA_W-1:0]      c_wdata,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_last,
  output logic                   busy
);

  localparam int DEPTH_A = MAX_M * MAX_K;
  localparam int DEPTH_B = MAX_K * MAX_N;
  localparam int DEPTH_C = MAX_M * MAX_N;
  localparam int PAW     = ADDR_A_BITS + 1;
  localparam int PBW     = ADDR_B_BITS + 1;
  localparam int CW      = ADDR_C_BITS + 1;

  localparam logic [PAW-1:0] FULL_A = PAW'(DEPTH_A);
  localparam logic [PBW-1:0] FULL_B = PBW'(DEPTH_B);

  logic [1:0]     state;
  logic [1:0]     loaded;
  logic [1:0]     loaded_nxt;
  logic [PAW-1:0] ptr_a;
  logic [PBW-1:0] ptr_b;
  logic [CW-1:0]  drain_idx;
  logic [CW-1:0]  total;

  logic acc_a;
  logic acc_b;
  logic full_a;
  logic full_b;
  logic a_we;
  logic b_we;
  logic c_wen;
  logic c_re;

  assign ld_ready  = (state == ST_LOAD);
  assign busy      = (state != ST_LOAD);
  assign eng_start = (state == ST_KICK);

  assign acc_a  = ld_ready && ld_valid && !ld_sel;
  assign acc_b  = ld_ready && ld_valid && ld_sel;
  assign full_a = (ptr_a == FULL_A);
  assign full_b = (ptr_b == FULL_B);
  assign a_we   = acc_a && !full_a;
  assign b_we   = acc_b && !full_b;

  assign loaded_nxt = loaded | {acc_b && ld_last, acc_a && ld_last};

  assign total = CW'(M_val) * CW'(N_val);

  assign c_wen = c_we && (state == ST_COMPUTE);

  // C is read only on issue cycles, so rd_data holds while the host stalls.
  assign c_re = (state == ST_DRAIN) && !rd_valid && (drain_idx < total);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      loaded    <= '0;
      ptr_a     <= '0;
      ptr_b     <= '0;
      ld_err    <= 1'b0;
      drain_idx <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (acc_a) begin
            if (full_a) ld_err <= 1'b1;
            else        ptr_a  <= ptr_a + PAW'(1);
            if (ld_last) ptr_a <= '0;
          end
          if (acc_b) begin
            if (full_b) ld_err <= 1'b1;
            else        ptr_b  <= ptr_b + PBW'(1);
            if (ld_last) ptr_b <= '0;
          end
          loaded <= loaded_nxt;
          if (loaded_nxt == 2'b11) state <= ST_KICK;
        end
        ST_KICK: begin
          state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (eng_done) begin
            state     <= ST_DRAIN;
            drain_idx <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!rd_valid) begin
            if (drain_idx < total) begin
              rd_valid <= 1'b1;
              rd_last  <= (drain_idx == total - CW'(1));
            end else begin
              // Empty result: nothing to stream.
              state     <= ST_LOAD;
              loaded    <= '0;
              drain_idx <= '0;
            end
          end else if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              state     <= ST_LOAD;
              loaded    <= '0;
              drain_idx <= '0;
            end else begin
              drain_idx <= drain_idx + CW'(1);
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  bram_sdp #(.DEPTH(DEPTH_A), .AW(ADDR_A_BITS)) u_ram_a (
    .clk   (clk),
    .rst   (rst),
    .we    (a_we),
    .waddr (ptr_a[ADDR_A_BITS-1:0]),
    .wdata (ld_data),
    .re    (1'b1),
    .raddr (a_addr),
    .rdata (a_rdata)
  );

  bram_sdp #(.DEPTH(DEPTH_B), .AW(ADDR_B_BITS)) u_ram_b (
    .clk   (clk),
    .rst   (rst),
    .we    (b_we),
    .waddr (ptr_b[ADDR_B_BITS-1:0]),
    .wdata (ld_data),
    .re    (1'b1),
    .raddr (b_addr),
    .rdata (b_rdata)
  );

  bram_sdp #(.DEPTH(DEPTH_C), .AW(ADDR_C_BITS)) u_ram_c (
    .clk   (clk),
    .rst   (rst),
    .we    (c_wen),
    .waddr (c_addr),
    .wdata (c_wdata),
    .re    (c_re),
    .raddr (drain_idx[ADDR_C_BITS-1:0]),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_matrix_bram_bank.sv
// Directed bench for matrix_bram_bank: load/kick/compute/drain flows,
// read latency, backpressure, overflow, ignored traffic and reset abort.
module tb_matrix_bram_bank;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  M_val;
  logic [4:0]  N_val;
  logic        ld_valid;
  logic        ld_ready;
  logic        ld_sel;
  logic        ld_last;
  logic [31:0] ld_data;
  logic        ld_err;
  logic        eng_start;
  logic        eng_done;
  logic [7:0]  a_addr;
  logic [31:0] a_rdata;
  logic [7:0]  b_addr;
  logic [31:0] b_rdata;
  logic        c_we;
  logic [7:0]  c_addr;
  logic [31:0] c_wdata;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        busy;

  int total_n = 0;
  int bad_n   = 0;

  logic [31:0] exp_c [4];

  typedef struct {
    logic [7:0]  a_addr;
    logic [31:0] a_exp;
    logic [7:0]  b_addr;
    logic [31:0] b_exp;
  } rd_vec_t;

  rd_vec_t vecs [4];

  matrix_bram_bank dut (
    .clk       (clk),
    .rst       (rst),
    .M_val     (M_val),
    .N_val     (N_val),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_last   (ld_last),
    .ld_data   (ld_data),
    .ld_err    (ld_err),
    .eng_start (eng_start),
    .eng_done  (eng_done),
    .a_addr    (a_addr),
    .a_rdata   (a_rdata),
    .b_addr    (b_addr),
    .b_rdata   (b_rdata),
    .c_we      (c_we),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic sel, input logic [31:0] d,
                           input logic last);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic load_ab();
    load_word(1'b0, 32'h3F800000, 1'b0);
    load_word(1'b0, 32'h40000000, 1'b0);
    load_word(1'b0, 32'h40400000, 1'b0);
    load_word(1'b0, 32'h40800000, 1'b1);
    chk("start_after_a", 32'(eng_start), 32'd0);
    load_word(1'b1, 32'h40A00000, 1'b0);
    load_word(1'b1, 32'h40C00000, 1'b0);
    load_word(1'b1, 32'h40E00000, 1'b0);
    load_word(1'b1, 32'h41000000, 1'b1);
  endtask

  task automatic write_c();
    for (int i = 0; i < 4; i++) begin
      c_we    = 1'b1;
      c_addr  = 8'(i);
      c_wdata = exp_c[i];
      step();
    end
    c_we = 1'b0;
  endtask

  task automatic finish_compute();
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
  endtask

  task automatic drain_words(input int n, input int bp_idx);
    for (int w = 0; w < n; w++) begin
      int k = 0;
      while (!rd_valid && k < 8) begin
        step();
        k++;
      end
      chk("rd_valid_rise", 32'(rd_valid), 32'd1);
      if (w == bp_idx) begin
        for (int h = 0; h < 5; h++) begin
          step();
          chk("bp_valid", 32'(rd_valid), 32'd1);
          chk("bp_data", rd_data, exp_c[w]);
        end
      end
      chk("rd_data", rd_data, exp_c[w]);
      chk("rd_last", 32'(rd_last), (w == n - 1) ? 32'd1 : 32'd0);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      chk("rd_bubble", 32'(rd_valid), 32'd0);
    end
    chk("back_to_load", 32'(ld_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    M_val    = 5'd2;
    N_val    = 5'd2;
    ld_valid = 1'b0;
    ld_sel   = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
    eng_done = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    c_we     = 1'b0;
    c_addr   = '0;
    c_wdata  = '0;
    rd_ready = 1'b0;

    vecs[0] = '{8'd3, 32'h40800000, 8'd0, 32'h40A00000};
    vecs[1] = '{8'd0, 32'h3F800000, 8'd3, 32'h41000000};
    vecs[2] = '{8'd2, 32'h40400000, 8'd1, 32'h40C00000};
    vecs[3] = '{8'd1, 32'h40000000, 8'd2, 32'h40E00000};

    #1 rst = 1'b1;
    step();
    step();
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(eng_start), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_last", 32'(rd_last), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_a_rdata", a_rdata, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;
    step();

    // Flow 1: 2x2x2 product.
    load_ab();
    chk("start_pulse", 32'(eng_start), 32'd1);
    chk("kick_busy", 32'(busy), 32'd1);
    chk("kick_ld_ready", 32'(ld_ready), 32'd0);
    step();
    chk("start_once", 32'(eng_start), 32'd0);
    ld_valid = 1'b1;
    #1;
    chk("compute_ld_ready", 32'(ld_ready), 32'd0);
    ld_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      a_addr = vecs[i].a_addr;
      b_addr = vecs[i].b_addr;
      step();
      chk("a_rdata_lat", a_rdata, vecs[i].a_exp);
      chk("b_rdata_lat", b_rdata, vecs[i].b_exp);
    end

    exp_c[0] = 32'h41980000;
    exp_c[1] = 32'h41B00000;
    exp_c[2] = 32'h422C0000;
    exp_c[3] = 32'h42480000;
    write_c();
    finish_compute();
    drain_words(4, 1);

    // c_we outside COMPUTE must not touch C.
    c_we    = 1'b1;
    c_addr  = 8'd0;
    c_wdata = 32'hDEADBEEF;
    step();
    c_we = 1'b0;

    // Flow 2: A overflow, then drain the untouched C.
    for (int i = 0; i < 257; i++) begin
      load_word(1'b0, 32'hA0000000 | 32'(i), (i == 256));
      if (i == 255) chk("err_at_depth", 32'(ld_err), 32'd0);
    end
    chk("err_overflow", 32'(ld_err), 32'd1);
    load_word(1'b1, 32'h40A00000, 1'b0);
    load_word(1'b1, 32'h41000000, 1'b1);
    chk("start_after_ovf", 32'(eng_start), 32'd1);
    step();
    a_addr = 8'd0;
    step();
    chk("ovf_a0", a_rdata, 32'hA0000000);
    a_addr = 8'd128;
    step();
    chk("ovf_a128", a_rdata, 32'hA0000080);
    a_addr = 8'd255;
    step();
    chk("ovf_a255", a_rdata, 32'hA00000FF);
    finish_compute();
    drain_words(4, -1);

    // Flow 3: empty result.
    M_val = 5'd0;
    load_word(1'b0, 32'h3F800000, 1'b1);
    load_word(1'b1, 32'h40A00000, 1'b1);
    chk("start_m0", 32'(eng_start), 32'd1);
    step();
    finish_compute();
    begin
      logic seen = 1'b0;
      int k = 0;
      while (!ld_ready && k < 6) begin
        seen = seen | rd_valid;
        step();
        k++;
      end
      seen = seen | rd_valid;
      chk("m0_no_valid", 32'(seen), 32'd0);
      chk("m0_to_load", 32'(ld_ready), 32'd1);
    end
    chk("err_sticky", 32'(ld_err), 32'd1);
    M_val = 5'd2;

    // Flow 4: reset in the middle of a drain.
    load_ab();
    step();
    exp_c[0] = 32'h11111111;
    exp_c[1] = 32'h22222222;
    exp_c[2] = 32'h33333333;
    exp_c[3] = 32'h44444444;
    write_c();
    finish_compute();
    step();
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    chk("pre_rst_data", rd_data, 32'h11111111);
    rst = 1'b1;
    step();
    chk("mid_rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_err", 32'(ld_err), 32'd0);
    rst = 1'b0;
    step();
    load_word(1'b1, 32'h40A00000, 1'b0);
    load_word(1'b1, 32'h40C00000, 1'b0);
    load_word(1'b1, 32'h40E00000, 1'b0);
    load_word(1'b1, 32'h41000000, 1'b1);
    chk("flags_cleared", 32'(eng_start), 32'd0);
    chk("still_load", 32'(ld_ready), 32'd1);
    load_word(1'b0, 32'h3F800000, 1'b0);
    load_word(1'b0, 32'h40000000, 1'b0);
    load_word(1'b0, 32'h40400000, 1'b0);
    load_word(1'b0, 32'h40800000, 1'b1);
    chk("start_after_rst", 32'(eng_start), 32'd1);
    step();
    exp_c[0] = 32'h41980000;
    exp_c[1] = 32'h41B00000;
    exp_c[2] = 32'h422C0000;
    exp_c[3] = 32'h42480000;
    write_c();
    finish_compute();
    drain_words(4, 2);

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
